e_mdu: RTL and testbench
========================

Name: e_mdu

Overview:
- Multiply/divide unit for the Execute stage of the 5-stage MIPS pipeline.
- Accepts mult/multu/div/divu from the E-stage instruction and models a multi-cycle latency with a busy flag. The hazard unit uses that flag to stall md-class instructions in D.
- Holds architectural HI/LO registers and supplies mfhi/mflo data alongside the ALU result into the E->M pipeline register.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (and madd family when enabled); legal range 1..15.
- DIV_CYCLES, 10, busy cycles for div/divu; legal range 1..15.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse launching the operation in md_op; sampled at posedge.
- md_op  input  3  operation code (encodings in package).
- rs_val  input  32  operand A (forwarded rs value in E).
- rt_val  input  32  operand B (forwarded rt value in E).
- mthi  input  1  write rs_val to HI this edge.
- mtlo  input  1  write rs_val to LO this edge.
- rd_hi  input  1  selects md_out: 1 = HI, 0 = LO.
- busy  output  1  operation in flight.
- hi  output  32  HI register.
- lo  output  32  LO register.
- md_out  output  32  rd_hi ? hi : lo (combinational, for mfhi/mflo into E->M register).

Behaviour:
- Reset, synchronous on posedge with reset=1:
  - hi=0, lo=0, busy=0, counter=0.
  - Any in-flight operation is discarded; no HI/LO write occurs afterwards.
- Launch:
  - Condition: start=1, busy=0, md_op is a valid multi-cycle op.
  - At that edge, rs_val/rt_val are latched into operand registers.
  - counter is loaded with MULT_CYCLES or DIV_CYCLES; busy goes 1.
- Countdown:
  - Each subsequent edge, counter decrements.
  - On the edge where counter==1: hi/lo are written with the result, counter becomes 0, busy becomes 0.
  - busy is therefore high for exactly N cycles after the launch edge; new hi/lo are visible in the same cycle busy falls.
- Results:
  - mult: {hi,lo} = signed 64-bit product.
  - multu: {hi,lo} = unsigned 64-bit product.
  - div: lo = signed quotient truncated toward zero, hi = remainder with the sign of the dividend.
  - divu: unsigned quotient/remainder.
- Divide by zero (rt_val latched as 0): busy timing is unchanged; hi/lo keep their prior values at completion.
- Ignored inputs:
  - start while busy=1: ignored; the running operation continues unaffected. The hazard unit guarantees this does not happen.
  - start with md_op=MD_NONE or an unsupported code: no effect, busy stays 0.
- mthi/mtlo:
  - Write on the edge when busy=0.
  - Ignored while busy=1.
  - Both asserted: both write rs_val.
  - mthi/mtlo with start at the same edge: start wins and mthi/mtlo are dropped.
- md_out is purely combinational from hi/lo/rd_hi. It does not reflect an in-flight result.
- No flush input: E-stage bubbles simply never assert start/mthi/mtlo.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined:
  - md_op codes MADD, MADDU, MSUB, MSUBU are valid; latency is MULT_CYCLES.
  - At completion, {hi,lo} becomes {hi,lo} ± product (signed or unsigned as named), 64-bit wrap-around.
  - The accumulate uses the {hi,lo} value present at the completion edge.
- Undefined: these four codes behave as unsupported (start ignored, busy stays 0).

Decomposition:
- Package e_mdu_pkg:
  - md_op localparams: MD_NONE=3'd0, MD_MULT=1, MD_MULTU=2, MD_DIV=3, MD_DIVU=4, MD_MADD=5, MD_MADDU=6, MD_MSUB=7. MSUBU shares code 7, distinguished by an msub_u bit decoded from the funct field.
  - Constant CNT_W=4.
- Sub-module e_mdu_core: combinational result calculation from latched operands, op code and current {hi,lo}; outputs res_hi, res_lo, res_valid (0 on divide by zero).
- Top e_mdu owns the counter, busy flag, operand and HI/LO registers.

Test Plan:
- mult, rs=3, rt=0xFFFFFFFC, start pulse -> busy=1 for exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFF4.
- divu, rs=7, rt=2 -> busy for 10 cycles, then lo=3, hi=1. Then div, rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- mthi rs=0x12345678, then div by rt=0 -> busy 10 cycles, hi stays 0x12345678, lo unchanged.
- mult launched; at cycle 3, start with divu and mtlo asserted -> both ignored; mult completes at cycle 5 with the correct product, busy falls at 5.
- div launched; reset asserted at cycle 4 -> next edge hi=lo=0, busy=0; no write at cycle 10.
- With MDU_MADD_EN: hi=0, lo=0xFFFFFFFF, madd rs=1, rt=1 -> after 5 cycles hi=1, lo=0. Without the macro, same stimulus -> busy stays 0, hi/lo unchanged.

Source files
------------

// File: rtl/e_mdu_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: op codes, counter width, op decode helpers.
// Optional multiply-accumulate ops are enabled with the MDU_MADD_EN macro.
package e_mdu_pkg;

  localparam int unsigned CNT_W = 4;

  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MADD  = 3'd5;
  localparam logic [2:0] MD_MADDU = 3'd6;
  // MSUB and MSUBU share this code; the msub_u bit tells them apart
  localparam logic [2:0] MD_MSUB  = 3'd7;

  function automatic logic md_op_valid(input logic [2:0] op);
`ifdef MDU_MADD_EN
    return op != MD_NONE;
`else
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
`endif
  endfunction

  function automatic logic md_op_is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/e_mdu_core.sv
// Combinational result datapath for the MDU: products, quotient/remainder and optional accumulate.
// res_valid_o is low for a divide by zero or an unsupported op; results then echo the current HI/LO.
module e_mdu_core
  import e_mdu_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [2:0]  op_i,
`ifdef MDU_MADD_EN
  input  logic        msub_u_i,
`endif
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  output logic [31:0] res_hi_o,
  output logic [31:0] res_lo_o,
  output logic        res_valid_o
);

  logic        signed_op;
  logic [63:0] prod;
  logic [31:0] a_mag, b_mag, b_div, q_mag, r_mag, quot, rem;

  always_comb begin
    signed_op = 1'b0;
    case (op_i)
      MD_MULT, MD_DIV: signed_op = 1'b1;
`ifdef MDU_MADD_EN
      MD_MADD:         signed_op = 1'b1;
      MD_MSUB:         signed_op = !msub_u_i;
`endif
      default:         signed_op = 1'b0;
    endcase
  end

  // Low 64 bits of the product of sign/zero-extended operands equal the true 64-bit product
  assign prod = {{32{signed_op & a_i[31]}}, a_i} * {{32{signed_op & b_i[31]}}, b_i};

  // Divide on magnitudes so the most-negative / -1 case wraps cleanly instead of overflowing
  assign a_mag = (signed_op && a_i[31]) ? -a_i : a_i;
  assign b_mag = (signed_op && b_i[31]) ? -b_i : b_i;
  assign b_div = (b_mag == '0) ? 32'd1 : b_mag;
  assign q_mag = a_mag / b_div;
  assign r_mag = a_mag % b_div;
  assign quot  = (signed_op && (a_i[31] ^ b_i[31])) ? -q_mag : q_mag;
  assign rem   = (signed_op && a_i[31]) ? -r_mag : r_mag;

  always_comb begin
    res_hi_o    = hi_i;
    res_lo_o    = lo_i;
    res_valid_o = 1'b1;
    case (op_i)
      MD_MULT, MD_MULTU: {res_hi_o, res_lo_o} = prod;
      MD_DIV, MD_DIVU: begin
        if (b_i == '0) begin
          res_valid_o = 1'b0;
        end else begin
          res_hi_o = rem;
          res_lo_o = quot;
        end
      end
`ifdef MDU_MADD_EN
      MD_MADD, MD_MADDU: {res_hi_o, res_lo_o} = {hi_i, lo_i} + prod;
      MD_MSUB:           {res_hi_o, res_lo_o} = {hi_i, lo_i} - prod;
`endif
      default: res_valid_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: owns HI/LO, latched operands and the busy countdown.
// MDU_MADD_EN adds the madd/maddu/msub/msubu ops and the msub_u select input.
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic        rd_hi,
`ifdef MDU_MADD_EN
  input  logic        msub_u,
`endif
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_out
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      a_q, a_d, b_q, b_d;
  logic [2:0]       op_q, op_d;
`ifdef MDU_MADD_EN
  logic             msu_q, msu_d;
`endif
  logic [31:0]      res_hi, res_lo;
  logic             res_valid;
  logic [CNT_W-1:0] latency;

  assign latency = md_op_is_div(md_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

  e_mdu_core u_core (
    .a_i         (a_q),
    .b_i         (b_q),
    .op_i        (op_q),
`ifdef MDU_MADD_EN
    .msub_u_i    (msu_q),
`endif
    .hi_i        (hi_q),
    .lo_i        (lo_q),
    .res_hi_o    (res_hi),
    .res_lo_o    (res_lo),
    .res_valid_o (res_valid)
  );

  // Busy blocks both new launches and mthi/mtlo; a valid launch takes priority over mthi/mtlo
  always_comb begin
    cnt_d  = cnt_q;
    busy_d = busy_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    a_d    = a_q;
    b_d    = b_q;
    op_d   = op_q;
`ifdef MDU_MADD_EN
    msu_d  = msu_q;
`endif
    if (busy_q) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        busy_d = 1'b0;
        if (res_valid) begin
          hi_d = res_hi;
          lo_d = res_lo;
        end
      end
    end else if (start && md_op_valid(md_op)) begin
      a_d    = rs_val;
      b_d    = rt_val;
      op_d   = md_op;
`ifdef MDU_MADD_EN
      msu_d  = msub_u;
`endif
      cnt_d  = latency;
      busy_d = 1'b1;
    end else begin
      if (mthi) hi_d = rs_val;
      if (mtlo) lo_d = rs_val;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= MD_NONE;
`ifdef MDU_MADD_EN
      msu_q  <= 1'b0;
`endif
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      a_q    <= a_d;
      b_q    <= b_d;
      op_q   <= op_d;
`ifdef MDU_MADD_EN
      msu_q  <= msu_d;
`endif
    end
  end

  assign busy   = busy_q;
  assign hi     = hi_q;
  assign lo     = lo_q;
  assign md_out = rd_hi ? hi_q : lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: a behavioural HI/LO model checked every cycle plus literal pins.
module tb_e_mdu;
  import e_mdu_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset, start, mthi, mtlo, rd_hi;
  logic [2:0]  md_op;
  logic [31:0] rs_val, rt_val;
`ifdef MDU_MADD_EN
  logic        msub_u;
`endif
  logic        busy;
  logic [31:0] hi, lo, md_out;

  int total = 0;
  int bad   = 0;

  e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .md_op  (md_op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .mthi   (mthi),
    .mtlo   (mtlo),
    .rd_hi  (rd_hi),
`ifdef MDU_MADD_EN
    .msub_u (msub_u),
`endif
    .busy   (busy),
    .hi     (hi),
    .lo     (lo),
    .md_out (md_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: pending op remembered with its remaining busy cycles
  logic [31:0] m_hi = '0, m_lo = '0, m_a, m_b;
  logic [2:0]  m_op;
  logic        m_su = 1'b0;
  int          m_left = 0;

  function automatic bit op_ok(input logic [2:0] op);
`ifdef MDU_MADD_EN
    return op != 3'd0;
`else
    return op >= 3'd1 && op <= 3'd4;
`endif
  endfunction

  task automatic finish_op();
    longint unsigned p;
    int sa, sb;
    bit sgn;
    sgn = (m_op == 3'd1) || (m_op == 3'd5) || (m_op == 3'd7 && !m_su);
    if (sgn) p = longint'($signed(m_a)) * longint'($signed(m_b));
    else     p = longint'({32'b0, m_a}) * longint'({32'b0, m_b});
    case (m_op)
      3'd1, 3'd2: {m_hi, m_lo} = p;
      3'd3: if (m_b != 0) begin
        sa = m_a; sb = m_b;
        m_lo = 32'(sa / sb);
        m_hi = 32'(sa % sb);
      end
      3'd4: if (m_b != 0) begin
        m_lo = m_a / m_b;
        m_hi = m_a % m_b;
      end
      3'd5, 3'd6: {m_hi, m_lo} = {m_hi, m_lo} + p;
      3'd7:       {m_hi, m_lo} = {m_hi, m_lo} - p;
      default: ;
    endcase
  endtask

  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        m_hi = '0; m_lo = '0; m_left = 0;
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) finish_op();
      end else if (start && op_ok(md_op)) begin
        m_op = md_op; m_a = rs_val; m_b = rt_val;
`ifdef MDU_MADD_EN
        m_su = msub_u;
`endif
        m_left = (md_op == 3'd3 || md_op == 3'd4) ? DC : MC;
      end else begin
        if (mthi) m_hi = rs_val;
        if (mtlo) m_lo = rs_val;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      chk("busy_model", {31'b0, busy}, {31'b0, m_left > 0});
      chk("hi_model", hi, m_hi);
      chk("lo_model", lo, m_lo);
      chk("md_out_model", md_out, rd_hi ? m_hi : m_lo);
    end
  end

  initial begin
    rd_hi = 1'b0;
    forever begin
      @(negedge clk);
      rd_hi = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation limit reached");
    $fatal(1, "timeout");
  end

  task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; md_op = op; rs_val = a; rt_val = b;
    @(negedge clk);
    start = 1'b0; md_op = MD_NONE;
  endtask

  task automatic wait_idle(input int already, input int exp, input string nm);
    int c;
    c = already;
    while (busy && c < 40) begin
      @(negedge clk);
      c++;
    end
    chk(nm, 32'(c), 32'(exp));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; md_op = MD_NONE; mthi = 1'b0; mtlo = 1'b0;
    rs_val = '0; rt_val = '0;
`ifdef MDU_MADD_EN
    msub_u = 1'b0;
`endif
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);

    launch(MD_MULT, 32'd3, 32'hFFFFFFFC);
    wait_idle(0, MC, "mult_len");
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFF4);

    launch(MD_DIVU, 32'd7, 32'd2);
    wait_idle(0, DC, "divu_len");
    chk("divu_lo", lo, 32'd3);
    chk("divu_hi", hi, 32'd1);
    launch(MD_DIV, 32'hFFFFFFF9, 32'd2);
    wait_idle(0, DC, "div_len");
    chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);

    mthi = 1'b1; rs_val = 32'h12345678;
    @(negedge clk);
    mthi = 1'b0;
    launch(MD_DIV, 32'd5, 32'd0);
    wait_idle(0, DC, "div0_len");
    chk("div0_hi", hi, 32'h12345678);
    chk("div0_lo", lo, 32'hFFFFFFFD);

    launch(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_idle(0, MC, "multu_len");
    chk("multu_hi", hi, 32'hFFFFFFFE);
    chk("multu_lo", lo, 32'h00000001);

    launch(MD_NONE, 32'd9, 32'd9);
    chk("none_busy", {31'b0, busy}, 32'd0);

    launch(MD_MULT, 32'h00010000, 32'h00010000);
    repeat (2) @(negedge clk);
    start = 1'b1; md_op = MD_DIVU; mtlo = 1'b1; rs_val = 32'hDEADBEEF; rt_val = 32'd2;
    @(negedge clk);
    start = 1'b0; md_op = MD_NONE; mtlo = 1'b0;
    wait_idle(3, MC, "ovl_len");
    chk("ovl_hi", hi, 32'd1);
    chk("ovl_lo", lo, 32'd0);

    mthi = 1'b1; mtlo = 1'b1; rs_val = 32'hA5A5A5A5;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    chk("mthilo_hi", hi, 32'hA5A5A5A5);
    chk("mthilo_lo", lo, 32'hA5A5A5A5);

    mthi = 1'b1;
    launch(MD_MULT, 32'd2, 32'd3);
    mthi = 1'b0;
    wait_idle(0, MC, "prio_len");
    chk("prio_hi", hi, 32'd0);
    chk("prio_lo", lo, 32'd6);

    launch(MD_DIV, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rstmid_busy", {31'b0, busy}, 32'd0);
    chk("rstmid_hi", hi, 32'd0);
    chk("rstmid_lo", lo, 32'd0);
    repeat (10) @(negedge clk);
    chk("rstmid_hi_late", hi, 32'd0);
    chk("rstmid_lo_late", lo, 32'd0);

    mtlo = 1'b1; rs_val = 32'hFFFFFFFF;
    @(negedge clk);
    mtlo = 1'b0;
    launch(MD_MADD, 32'd1, 32'd1);
`ifdef MDU_MADD_EN
    wait_idle(0, MC, "madd_len");
    chk("madd_hi", hi, 32'd1);
    chk("madd_lo", lo, 32'd0);
    launch(MD_MSUB, 32'd2, 32'd3);
    wait_idle(0, MC, "msub_len");
    chk("msub_hi", hi, 32'd0);
    chk("msub_lo", lo, 32'hFFFFFFFA);
`else
    chk("madd_off_busy", {31'b0, busy}, 32'd0);
    repeat (6) @(negedge clk);
    chk("madd_off_hi", hi, 32'd0);
    chk("madd_off_lo", lo, 32'hFFFFFFFF);
`endif

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
